// File: rtl/processor_sample_capture.sv
// processor_sample_capture: PIO-controlled sampler of a digital bus into a FIFO drained over Avalon-MM
module processor_sample_capture #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        ctrl_in,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, next_state;
    logic              run, clear, tick, pop, push, full, empty, div_wr, stat_wr, ovf, unused_bits;
    logic [DATA_W-1:0] din_s1, din_s2;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [DIV_W-1:0]  presc, divider;

    assign run         = ctrl_in[0];
    assign clear       = ctrl_in[1];
    assign full        = count == (AW+1)'(DEPTH);
    assign empty       = count == '0;
    assign pop         = chipselect && !read_n && address == 2'd0 && !empty;
    assign push        = tick && (!full || pop);
    assign div_wr      = chipselect && !write_n && address == 2'd2;
    assign stat_wr     = chipselect && !write_n && address == 2'd1;
    assign irq         = !empty || ovf;
    assign unused_bits = ^writedata;

    // two-flop synchroniser for the asynchronous input bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_s1 <= '0;
            din_s2 <= '0;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
        end
    end

    // capture state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // run only while RUN is set and CLEAR is not
    always_comb begin
        next_state = (state == IDLE) ? ((run && !clear) ? RUN : IDLE)
                                     : ((!run || clear) ? IDLE : RUN);
    end

    // a tick opens each sample period, so sampling starts on the first RUN cycle
    always_comb begin
        tick = state == RUN && presc == '0 && !clear;
    end

    // prescaler counts 0..divider; held at 0 outside RUN and restarted by a divider write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            presc <= '0;
        else if (clear || state != RUN || div_wr) presc <= '0;
        else                                     presc <= (presc == divider) ? '0 : presc + DIV_W'(1);
    end

    // divider register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    divider <= DIV_W'(DIV_RESET);
        else if (div_wr) divider <= writedata[DIV_W-1:0];
    end

    // FIFO storage; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din_s2;
    end

    // FIFO pointers, occupancy and sticky overflow; CLEAR flushes everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (tick && full && !pop)          ovf <= 1'b1;
            else if (stat_wr && writedata[31]) ovf <= 1'b0;
        end
    end

    // register read mux, combinational from address
    always_comb begin
        readdata = (address == 2'd0) ? (empty ? 32'd0 : 32'(mem[rd_ptr])) :
                   (address == 2'd1) ? {ovf, 13'd0, full, empty, 16'(count)} :
                   (address == 2'd2) ? 32'(divider) : 32'd0;
    end
endmodule

// File: tb/tb_processor_sample_capture.sv
// tb_processor_sample_capture: directed stimulus checked against a queue-based model
module tb_processor_sample_capture;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [1:0]  ctrl_in = 2'b00;
    logic [7:0]  din = 8'h00;
    logic [1:0]  address = 2'd1;
    logic        chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;

    int vectors = 0, miscompares = 0;

    logic [7:0] q[$];
    bit         m_ovf = 0, m_running = 0;
    int         m_div = 0, m_elapsed = 0;
    logic [7:0] d0 = 0, d1 = 0;

    processor_sample_capture dut (
        .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .din(din),
        .address(address), .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(logic [1:0] a);
        if (a == 2'd0) return (q.size() > 0) ? {24'd0, q[0]} : 32'd0;
        if (a == 2'd1) return {m_ovf, 13'd0, q.size() == DEPTH, q.size() == 0, 16'(q.size())};
        if (a == 2'd2) return 32'(m_div);
        return 32'd0;
    endfunction

    // model: FIFO as a queue, sample period as elapsed-cycles modulo (divider+1)
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_ovf = 0; m_running = 0; m_div = 0; m_elapsed = 0; d0 = 0; d1 = 0;
        end else begin
            bit do_pop, do_tick, wr, restart;
            logic [7:0] smp;
            do_pop  = chipselect && !read_n && address == 2'd0 && q.size() > 0;
            wr      = chipselect && !write_n;
            do_tick = m_running && (m_elapsed % (m_div + 1)) == 0;
            restart = wr && address == 2'd2;
            smp = d1; d1 = d0; d0 = din;
            if (ctrl_in[1]) begin
                q.delete();
                m_ovf = 0;
            end else begin
                if (do_pop) void'(q.pop_front());
                if (wr && address == 2'd1 && writedata[31]) m_ovf = 0;
                if (do_tick) begin
                    if (q.size() < DEPTH) q.push_back(smp);
                    else m_ovf = 1;
                end
            end
            if (restart) m_div = int'(writedata[15:0]);
            m_elapsed = (!m_running || restart || ctrl_in[1]) ? 0 : m_elapsed + 1;
            m_running = ctrl_in == 2'b01;
        end
    end

    always @(negedge clk) begin
        check("irq", {31'd0, irq}, {31'd0, q.size() > 0 || m_ovf});
        check("readdata", readdata, exp_rd(address));
    end

    task automatic cyc(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1; write_n = 0;
        cyc();
        chipselect = 0; write_n = 1; address = 2'd1;
    endtask

    task automatic lit(string name, logic [1:0] a, logic [31:0] exp);
        address = a;
        #2;
        check(name, readdata, exp);
    endtask

    task automatic rd_data(logic [31:0] exp, bit chk);
        address = 2'd0; chipselect = 1; read_n = 0;
        #2;
        if (chk) check("data_read", readdata, exp);
        cyc();
        chipselect = 0; read_n = 1; address = 2'd1;
    endtask

    initial begin
        cyc(2);
        reset_n = 1;
        lit("reset_status", 2'd1, 32'h0001_0000);
        check("reset_irq", {31'd0, irq}, 32'd0);
        // 1: divider 3, steady A5
        wr(2'd2, 32'd3);
        din = 8'hA5;
        cyc(3);
        ctrl_in = 2'b01;
        cyc(1); lit("t1_before_push", 2'd1, 32'h0001_0000);
        cyc(1); lit("t1_first_push", 2'd1, 32'h0000_0001);
        cyc(3); lit("t1_gap", 2'd1, 32'h0000_0001);
        cyc(1); lit("t1_second_push", 2'd1, 32'h0000_0002);
        rd_data(32'hA5, 1);
        lit("t1_after_pop", 2'd1, 32'h0000_0001);
        ctrl_in = 2'b00; cyc(1);
        ctrl_in = 2'b10; cyc(1);
        ctrl_in = 2'b00; cyc(1);
        lit("t1_cleared", 2'd1, 32'h0001_0000);
        // 2: divider 0, 20 cycles of RUN, no reads
        wr(2'd2, 32'd0);
        ctrl_in = 2'b01; din = 8'h20;
        repeat (20) begin cyc(1); din = din + 8'd1; end
        ctrl_in = 2'b00; cyc(1);
        lit("t2_full_ovf", 2'd1, 32'h8002_0010);
        check("t2_irq", {31'd0, irq}, 32'd1);
        wr(2'd1, 32'h8000_0000);
        lit("t2_ovf_cleared", 2'd1, 32'h0002_0010);
        rd_data(32'hA5, 1);
        rd_data(32'h20, 1);
        lit("t2_after_pops", 2'd1, 32'h0000_000E);
        // 3: full FIFO, pop on a tick cycle
        ctrl_in = 2'b10; din = 8'h3C; cyc(1);
        ctrl_in = 2'b00; cyc(1);
        ctrl_in = 2'b01;
        cyc(15); din = 8'h77;
        cyc(2);
        lit("t3_full", 2'd1, 32'h0002_0010);
        ctrl_in = 2'b00;
        rd_data(32'h3C, 1);
        lit("t3_pop_push_full", 2'd1, 32'h0002_0010);
        repeat (15) rd_data(32'h3C, 1);
        rd_data(32'h77, 1);
        lit("t3_drained", 2'd1, 32'h0001_0000);
        // 4: overflow with simultaneous clear write, then CLEAR pulse at 5 entries
        ctrl_in = 2'b01;
        cyc(19);
        ctrl_in = 2'b00;
        wr(2'd1, 32'h8000_0000);
        lit("t4_set_wins", 2'd1, 32'h8002_0010);
        repeat (11) rd_data(32'd0, 0);
        lit("t4_five_ovf", 2'd1, 32'h8000_0005);
        ctrl_in = 2'b10; cyc(1);
        ctrl_in = 2'b00;
        lit("t4_cleared", 2'd1, 32'h0001_0000);
        check("t4_irq", {31'd0, irq}, 32'd0);
        rd_data(32'd0, 1);
        lit("t4_empty_read", 2'd1, 32'h0001_0000);
        // 5: ramp on din, pointers wrapped by earlier traffic
        din = 8'h00;
        ctrl_in = 2'b10; cyc(1);
        ctrl_in = 2'b00; cyc(1);
        ctrl_in = 2'b01; din = 8'h01;
        for (int k = 2; k <= 10; k++) begin cyc(1); din = 8'(k); end
        cyc(1); ctrl_in = 2'b00; cyc(1);
        lit("t5_count", 2'd1, 32'h0000_000A);
        for (int k = 0; k < 4; k++) rd_data(32'(k), 1);
        repeat (6) rd_data(32'd0, 0);
        lit("t5_drained", 2'd1, 32'h0001_0000);
        // 6: async reset mid-RUN with 7 entries
        ctrl_in = 2'b10; cyc(1);
        ctrl_in = 2'b00;
        wr(2'd2, 32'd1);
        ctrl_in = 2'b01;
        cyc(14);
        lit("t6_count7", 2'd1, 32'h0000_0007);
        reset_n = 0;
        #1;
        lit("t6_reset_status", 2'd1, 32'h0001_0000);
        lit("t6_reset_div", 2'd2, 32'd0);
        check("t6_reset_irq", {31'd0, irq}, 32'd0);
        ctrl_in = 2'b00; address = 2'd1;
        cyc(2);
        reset_n = 1;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
